// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] mk_flag(input logic c, input logic z,
                                         input logic n, input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_C] = c;
    f[F_Z] = z;
    f[F_N] = n;
    f[F_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per step, product formed in {acc,mplr}.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_nxt,
  output logic               last
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand, acc, mplr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // prod_nxt is what {acc,mplr} becomes after this step; on the last step it is the product
  always_comb begin
    sum      = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    prod_nxt = {sum, mplr[WIDTH-1:1]};
    last     = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= '0;
      mplr  <= b;
      cnt   <= CW'(WIDTH);
    end else if (step) begin
      acc   <= sum[WIDTH:1];
      mplr  <= {sum[0], mplr[WIDTH-1:1]};
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: start/busy/done handshake, registered result and {C,Z,N,V} flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       fs,
  input  logic [WIDTH-1:0] R0,
  input  logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R2_hi,
  output logic [3:0]       flag,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);

  state_t             state, state_n;
  logic [2:0]         op;
  logic [WIDTH-1:0]   shreg, sh_nxt, res_s;
  logic [SW-1:0]      cnt, n_in;
  logic [WIDTH:0]     add_r, sub_r;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               accept, go_exec, last, mul_last, c_s, v_s, c_sh, wr;
  logic [WIDTH-1:0]   r2_n, hi_n;
  logic [3:0]         fl_n;

  assign busy   = (state == S_EXEC);
  assign done   = (state == S_DONE);
  assign accept = start && (state != S_EXEC);
  assign n_in   = R1[SW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && fs == OP_MUL),
    .step     (state == S_EXEC && op == OP_MUL),
    .a        (R0),
    .b        (R1),
    .prod_nxt (prod_nxt),
    .last     (mul_last)
  );

  // Single-cycle results straight from the operand inputs; shifts by 0 fall through as R0
  always_comb begin
    add_r = {1'b0, R0} + {1'b0, R1};
    sub_r = {1'b0, R0} - {1'b0, R1};
    res_s = R0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (fs)
      OP_ADD: begin
        res_s = add_r[WIDTH-1:0];
        c_s   = add_r[WIDTH];
        v_s   = (R0[WIDTH-1] == R1[WIDTH-1]) && (add_r[WIDTH-1] != R0[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = sub_r[WIDTH-1:0];
        c_s   = sub_r[WIDTH];
        v_s   = (R0[WIDTH-1] != R1[WIDTH-1]) && (sub_r[WIDTH-1] != R0[WIDTH-1]);
      end
      OP_AND:  res_s = R0 & R1;
      OP_OR:   res_s = R0 | R1;
      OP_XOR:  res_s = R0 ^ R1;
      default: res_s = R0;
    endcase
    go_exec = (fs == OP_MUL) || ((fs == OP_SHL || fs == OP_SHR) && n_in != '0);
  end

  always_comb begin
    sh_nxt = (op == OP_SHL) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    c_sh   = (op == OP_SHL) ? shreg[WIDTH-1] : shreg[0];
    last   = (op == OP_MUL) ? mul_last : (cnt == SW'(1));
  end

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    r2_n    = R2;
    hi_n    = R2_hi;
    fl_n    = flag;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          if (go_exec) begin
            state_n = S_EXEC;
          end else begin
            state_n = S_DONE;
            wr      = 1'b1;
            r2_n    = res_s;
            hi_n    = '0;
            fl_n    = mk_flag(c_s, res_s == '0, res_s[WIDTH-1], v_s);
          end
        end
      end
      S_EXEC: begin
        if (last) begin
          state_n = S_DONE;
          wr      = 1'b1;
          if (op == OP_MUL) begin
            r2_n = prod_nxt[WIDTH-1:0];
            hi_n = prod_nxt[2*WIDTH-1:WIDTH];
            fl_n = mk_flag(hi_n != '0, prod_nxt == '0, hi_n[WIDTH-1], hi_n != '0);
          end else begin
            r2_n = sh_nxt;
            hi_n = '0;
            fl_n = mk_flag(c_sh, sh_nxt == '0, sh_nxt[WIDTH-1], 1'b0);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= '0;
      shreg <= '0;
      cnt   <= '0;
      R2    <= '0;
      R2_hi <= '0;
      flag  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op    <= fs;
        shreg <= R0;
        cnt   <= n_in;
      end else if (state == S_EXEC && op != OP_MUL) begin
        shreg <= sh_nxt;
        cnt   <= cnt - 1'b1;
      end
      if (wr) begin
        R2    <= r2_n;
        R2_hi <= hi_n;
        flag  <= fl_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level reference model checked every cycle, plus directed literals.
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] fs;
  logic [W-1:0] R0, R1, R2, R2_hi;
  logic [3:0] flag;
  logic busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .fs(fs), .R0(R0), .R1(R1),
    .R2(R2), .R2_hi(R2_hi), .flag(flag), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-operation reference: result, flags and the number of extra cycles it occupies
  function automatic void ref_op(input int f, input int a, input int b,
                                 output int r, output int hi, output int fl, output int k);
    int mask, n, s, p, c, v, z, ng;
    mask = (1 << W) - 1;
    n = b % W;
    c = 0; v = 0; hi = 0; k = 0; r = 0;
    case (f)
      0: begin s = a + b; r = s & mask; c = s >> W;
           v = (((a >> (W-1)) & 1) == ((b >> (W-1)) & 1)) && (((r >> (W-1)) & 1) != ((a >> (W-1)) & 1)); end
      1: begin r = (a - b) & mask; c = (a < b) ? 1 : 0;
           v = (((a >> (W-1)) & 1) != ((b >> (W-1)) & 1)) && (((r >> (W-1)) & 1) != ((a >> (W-1)) & 1)); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << n) & mask; c = (n != 0) ? ((a >> (W - n)) & 1) : 0; k = n; end
      6: begin r = a >> n; c = (n != 0) ? ((a >> (n - 1)) & 1) : 0; k = n; end
      default: begin p = a * b; r = p & mask; hi = p >> W; c = (hi != 0) ? 1 : 0; v = c; k = W; end
    endcase
    if (f == 7) begin z = (r == 0 && hi == 0) ? 1 : 0; ng = (hi >> (W-1)) & 1; end
    else        begin z = (r == 0) ? 1 : 0;             ng = (r >> (W-1)) & 1; end
    fl = (c << 3) | (z << 2) | (ng << 1) | v;
  endfunction

  // Model state: what the outputs must read in the cycle after each rising edge
  bit pend = 0, e_busy = 0, e_done = 0, chk_en = 0;
  int ecyc = 0, c_edge = 0;
  int p_r, p_hi, p_fl, p_k;
  int e_r2 = 0, e_hi = 0, e_fl = 0;

  always @(posedge clk) begin
    ecyc++;
    e_done = 0;
    if (rst) begin
      pend = 0; e_r2 = 0; e_hi = 0; e_fl = 0;
    end else if (!pend && start) begin
      ref_op(int'(fs), int'(R0), int'(R1), p_r, p_hi, p_fl, p_k);
      if (p_k == 0) begin e_r2 = p_r; e_hi = p_hi; e_fl = p_fl; e_done = 1; end
      else begin pend = 1; c_edge = ecyc + p_k; end
    end else if (pend && ecyc == c_edge) begin
      e_r2 = p_r; e_hi = p_hi; e_fl = p_fl; e_done = 1; pend = 0;
    end
    e_busy = pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("R2", R2, e_r2);
      chk("R2_hi", R2_hi, e_hi);
      chk("flag", flag, e_fl);
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input int er, input int eh, input int ef, input int elat,
                       input string nm, input bit poke);
    int lat;
    bit got;
    @(negedge clk);
    fs = f; R0 = a; R1 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      if (poke) begin
        start = (lat == 3);
        fs = 3'd0; R0 = W'($urandom); R1 = W'($urandom);
      end
    end
    start = 1'b0;
    chk({nm, " lat"}, got ? lat : -1, elat);
    chk({nm, " R2"}, R2, er);
    chk({nm, " R2_hi"}, R2_hi, eh);
    chk({nm, " flag"}, flag, ef);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; fs = '0; R0 = '0; R1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst R2", R2, 0);
    chk("rst R2_hi", R2_hi, 0);
    chk("rst flag", flag, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst = 1'b0;
    chk_en = 1;

    do_op(3'd0, 8'h02, 8'h01, 'h03, 0, 4'b0000, 1, "add1", 0);
    do_op(3'd0, 8'h7F, 8'h01, 'h80, 0, 4'b0011, 1, "add_ovf", 0);
    do_op(3'd1, 8'h12, 8'h12, 'h00, 0, 4'b0100, 1, "sub_z", 0);
    do_op(3'd1, 8'h01, 8'h02, 'hFF, 0, 4'b1010, 1, "sub_brw", 0);
    do_op(3'd0, 8'h23, 8'hFD, 'h20, 0, 4'b1000, 1, "add_c", 0);
    do_op(3'd2, 8'hF0, 8'h3C, 'h30, 0, 4'b0000, 1, "and", 0);
    do_op(3'd5, 8'h81, 8'h03, 'h08, 0, 4'b0000, 4, "shl3", 0);
    do_op(3'd5, 8'h81, 8'h01, 'h02, 0, 4'b1000, 2, "shl1", 0);
    do_op(3'd6, 8'h81, 8'h00, 'h81, 0, 4'b0010, 1, "shr0", 0);
    do_op(3'd6, 8'h81, 8'h0A, 'h20, 0, 4'b0000, 3, "shr2", 0);
    do_op(3'd7, 8'h0F, 8'h11, 'hFF, 0, 4'b0000, 9, "mul1", 1);
    do_op(3'd7, 8'h10, 8'h10, 'h00, 1, 4'b1001, 9, "mul2", 0);

    // abort a multiply with reset: no done, everything cleared
    @(negedge clk);
    fs = 3'd7; R0 = 8'hFF; R1 = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort R2_hi", R2_hi, 0);
    chk("abort flag", flag, 0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (done) seen++; end
    chk("abort no done", seen, 0);
    do_op(3'd4, 8'hA5, 8'h0F, 'hAA, 0, 4'b0010, 1, "xor_after", 0);

    // random traffic: back-to-back starts, ignored starts, occasional reset
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      fs = 3'($urandom);
      R0 = W'($urandom);
      R1 = W'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the combinational 8-bit ALU in the uPx1 datapath.
- Width is generic. Operands are latched on a start/busy/done handshake, and results and flags are held in registers.
- Adds three operations the combinational ALU does not have: logical shift left, logical shift right and a multi-cycle shift-add multiply.
- Sits between the register file (R0/R1 source, R2 destination) and the control unit, which issues start and waits for done.

Parameters:
- WIDTH, 8, operand/result width; power of two, minimum 4.
- SW, clog2(WIDTH), local (not overridable); shift-amount width.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- fs  in  3  operation select, latched with start.
- R0  in  WIDTH  operand A, latched with start.
- R1  in  WIDTH  operand B, latched with start.
- R2  out  WIDTH  result, low half for MUL; registered.
- R2_hi  out  WIDTH  high half of the MUL product; 0 for all other ops.
- flag  out  4  {C,Z,N,V}: flag[3]=C, flag[2]=Z, flag[1]=N, flag[0]=V; registered.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when R2/R2_hi/flag update.

Behaviour:
- Reset: R2=0, R2_hi=0, flag=0, busy=0, done=0, FSM=IDLE, internal counter=0.
- Reset mid-operation aborts the operation; no done pulse is generated.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: start=1 latches fs/R0/R1. Single-cycle ops go to DONE; SHL/SHR/MUL go to EXEC.
  - EXEC: runs the counter; goes to DONE when the count expires.
  - DONE: done=1 for one cycle, outputs update, then back to IDLE.
- Back-to-back: start may be reasserted in the cycle done is high and is accepted as a new request.
- Latency, with start sampled at edge t:
  - Single-cycle ops: done high in cycle t+1.
  - Shifts: done high in cycle t+n+1, where n = R1[SW-1:0].
  - MUL: done high in cycle t+WIDTH+1.
- start while busy=1 is ignored; the latched operands are unaffected.
- R2/R2_hi/flag hold their previous values while busy and change only in the done cycle.
- Opcodes:
  - 000 ADD: {C,R2} = R0+R1. V = signed overflow (operand signs equal, result sign differs).
  - 001 SUB: R2 = R0-R1. C = borrow (R0<R1 unsigned). V = signed overflow (operand signs differ, result sign differs from R0).
  - 010 AND, 011 OR, 100 XOR: bitwise; C=0, V=0.
  - 101 SHL, 110 SHR: logical shift by n = R1[SW-1:0] (R1 mod WIDTH), one bit per EXEC cycle.
    - C = last bit shifted out; C=0 when n=0.
    - n=0 passes R0 through with 1-cycle latency.
    - V=0.
  - 111 MUL: unsigned shift-add, one partial product per cycle, WIDTH cycles.
    - {R2_hi,R2} = R0*R1.
    - C = V = (R2_hi != 0).
- Flags:
  - Z: result == 0. For MUL, Z is computed over the full 2*WIDTH product.
  - N: R2[WIDTH-1]. For MUL, N = R2_hi[WIDTH-1].
- Shift amounts of WIDTH or more are impossible by construction (modulo WIDTH).

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - flag bit indices F_C=3, F_Z=2, F_N=1, F_V=0;
  - FSM state encodings S_IDLE, S_EXEC, S_DONE.
- One sub-module, alu_mul_seq: the shift-add multiplier datapath (accumulator, multiplier shift register, counter) with a load/step interface.
- Control FSM, shifter and single-cycle ops stay in alu_seq.

Test Plan (WIDTH=8):
1. ADD R0=0x02, R1=0x01, start at t -> done at t+1; R2=0x03, flag=0000. Then ADD 0x7F+0x01 -> R2=0x80, flag=0011 (N=1, V=1).
2. SUB R0=0x12, R1=0x12 -> R2=0x00, flag=0100 (Z=1). Then SUB 0x01-0x02 -> R2=0xFF, flag=1010 (C=1 borrow, N=1).
3. ADD R0=0x23, R1=0xFD -> R2=0x20, flag=1000 (C=1, V=0). Then AND 0xF0,0x3C -> R2=0x30, flag=0000.
4. SHL R0=0x81, R1=0x03 -> busy for 3 cycles, done at t+4; R2=0x08, C=0. Then SHL by 1 -> R2=0x02, C=1. SHR 0x81 by 0 -> R2=0x81, done at t+1.
5. MUL 0x0F*0x11 -> done at t+9; R2=0xFF, R2_hi=0x00, flag=0000. Then MUL 0x10*0x10 -> R2=0x00, R2_hi=0x01, flag=1001. start pulsed mid-MUL is ignored.
6. MUL in progress, rst=1 at cycle t+4 -> next edge: busy=0, R2=0, R2_hi=0, flag=0, and no done pulse. A fresh ADD afterwards completes normally.
